pi_integrator_mc: RTL and testbench
===================================

Name: pi_integrator_mc

Overview:
Multi-channel, time-multiplexed fixed-point PI (trapezoidal) integrator with output clamping. It implements y[n] = sat(y[n-1] + A*x[n] + B*x[n-1]) per channel, where A = (dt/2)*Ki + Kp and B = (dt/2)*Ki - Kp. Per-channel x/y history is held in internal state arrays, so no external FIFOs are needed. It sits in the wind-turbine control chain and serves N_CH turbines through one shared multiplier/adder pipeline.

Parameters:
- DATA_W, 32: signed two's-complement sample width (x, y, A, B, limits).
- FRAC_W, 16: fractional bits, Q(DATA_W-FRAC_W).FRAC_W. Range 1..DATA_W-2.
- N_CH, 8: number of channels (turbines), ≥1.
- CH_W, 3: channel index width, ≥ clog2(N_CH), ≥1.
- A, 32'h0001_8000: coefficient on x[n].
- B, 32'hFFFF_8000: coefficient on x[n-1].
- UPPER, 32'h0002_0000: upper clamp. UPPER ≥ LOWER is required.
- LOWER, 32'hFFFE_0000: lower clamp.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clr  in  1  one-cycle pulse: zero all channel state
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted on edge where in_valid&in_ready
- in_ch  in  CH_W  channel index of sample
- in_x  in  DATA_W  input error sample
- in_freeze  in  1  hold integrator for this sample
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CH_W  channel of result
- out_y  out  DATA_W  clamped result
- out_sat  out  1  result was clamped
- busy  out  1  clear sequence in progress

Behaviour:
- Reset (async) takes effect immediately:
  - out_valid=0, out_ch=0, out_y=0, out_sat=0, busy=0.
  - All pipeline valids are cleared.
  - Every channel's x_prev=0 and y_prev=0. Reset must be able to zero the state arrays, so they are built as registers, not RAM.
- Pipeline runs 1 sample/cycle. Accept edge k:
  - S1 (after k): register x, ch, freeze, plus x_prev[ch] and y_prev[ch].
  - S2 (k+1): full-precision products P1=A*x and P2=B*x_prev, each 2*DATA_W signed.
  - S3 (k+2): S = (y_prev <<< FRAC_W) + P1 + P2 + 2^(FRAC_W-1), computed at 2*DATA_W+2 bits. Then R = S >>> FRAC_W (arithmetic shift, so round-half-toward-+inf).
  - Output (edge k+3):
    - If R>UPPER: out_y=UPPER, out_sat=1.
    - Else if R<LOWER: out_y=LOWER, out_sat=1.
    - Else out_y=R[DATA_W-1:0], out_sat=0.
  - out_valid is high for exactly one cycle following edge k+3, i.e. latency 3.
- State write on edge k+3:
  - x_prev[ch]=x always.
  - y_prev[ch]=out_y, so the stored integrator is the clamped value (anti-windup by clamping).
- Freeze (in_freeze=1):
  - out_y = y_prev[ch] unchanged; products are ignored and no clamp check is made, so out_sat=0.
  - x_prev[ch] is still updated; y_prev is unchanged.
- Hazard interlock:
  - in_ready=0 when in_ch equals the channel of any valid entry in S1, S2 or S3.
  - Consequently, same-channel samples are spaced ≥4 cycles apart, and every sample reads fully updated state. No forwarding is used.
  - With ≥4 distinct channels issued round-robin, throughput is 1 sample/cycle.
- in_ch ≥ N_CH: the sample is accepted but dropped. No state write and no out_valid.
- Clear:
  - A clr pulse with busy=0 raises busy on the next edge and lowers in_ready.
  - The block drains the in-flight pipeline, whose results are output normally. It then zeroes one channel per cycle, ch 0..N_CH-1, and deasserts busy after the last one. Total busy cycles = 3 + N_CH.
  - clr while busy=1 is ignored.
  - clr asserted in the same cycle as an accepted sample: the sample is accepted, completes, and is then zeroed by the clear.
- in_ready=0 whenever busy=1 or while in reset.
- Reset asserted mid-operation aborts everything: in-flight samples produce no output.

Test Plan:
- Step response (defaults, FRAC_W=16). Reset, then ch0 in_x=0x10000 → out_y=0x18000, out_sat=0 three cycles later. Repeat ch0 x=0x10000 → 0x28000 clamps to 0x20000, out_sat=1. Repeat again → 0x20000+0x18000-0x8000 clamps to 0x20000, out_sat=1.
- Rounding. Fresh ch1, x=0x00000001 → out_y=0x00000002. Fresh ch2, x=0xFFFFFFFF → out_y=0xFFFFFFFF.
- Interlock and throughput:
  - in_valid held, in_ch sequence 3,3: second accept occurs exactly 4 edges after the first.
  - Round-robin ch0..7: in_ready stays 1, and 8 consecutive out_valid pulses carry the correct per-channel results.
- Freeze. ch4 with y_prev=0x18000, x_prev=0x10000. Send x=0x20000 with in_freeze=1 → out_y=0x18000. Then x=0 unfrozen → 0x18000 + 0 + (-0.5*0x20000) = 0x8000.
- Clear. Load nonzero state in all channels, pulse clr → busy high for 3+8=11 cycles with in_ready=0. Afterwards, ch0 x=0x10000 → 0x18000.
- Async reset mid-stream. Assert rst while 3 samples are in flight → no out_valid. Outputs are 0 during reset. After release, ch0 x=0x10000 → 0x18000.

Source files
------------

// File: rtl/pi_integrator_mc_if.sv
// Sample/result bus for the multi-channel PI integrator.
// master: the controller issuing samples; slave: the integrator.
interface pi_integrator_mc_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 3
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_x;
    logic              in_freeze;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_y;
    logic              out_sat;
    logic              busy;

    modport master (
        output clr, in_valid, in_ch, in_x, in_freeze,
        input  in_ready, out_valid, out_ch, out_y, out_sat, busy
    );

    modport slave (
        input  clr, in_valid, in_ch, in_x, in_freeze,
        output in_ready, out_valid, out_ch, out_y, out_sat, busy
    );
endinterface

// File: rtl/pi_integrator_mc.sv
// Time-multiplexed trapezoidal PI integrator with output clamping.
// y[n] = sat(y[n-1] + A*x[n] + B*x[n-1]) per channel, one shared
// 3-stage multiply/add pipeline, per-channel history in register arrays.
//
// Clear sequencer states:
//   state    | meaning
//   ST_IDLE  | normal operation, clr accepted
//   ST_DRAIN | in-flight samples finish (3 cycles), no new samples
//   ST_ZERO  | zero one channel per cycle, 0..N_CH-1
module pi_integrator_mc #(
    parameter int                DATA_W = 32,
    parameter int                FRAC_W = 16,
    parameter int                N_CH   = 8,
    parameter int                CH_W   = 3,
    parameter logic [DATA_W-1:0] A      = 32'h0001_8000,
    parameter logic [DATA_W-1:0] B      = 32'hFFFF_8000,
    parameter logic [DATA_W-1:0] UPPER  = 32'h0002_0000,
    parameter logic [DATA_W-1:0] LOWER  = 32'hFFFE_0000
) (
    input logic              clk,
    input logic              rst,
    pi_integrator_mc_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam int W2 = 2 * DATA_W + 2;

    localparam logic [PW-1:0]        A_W   = {{DATA_W{A[DATA_W-1]}}, A};
    localparam logic [PW-1:0]        B_W   = {{DATA_W{B[DATA_W-1]}}, B};
    localparam logic signed [W2-1:0] UP_W  = {{(W2-DATA_W){UPPER[DATA_W-1]}}, UPPER};
    localparam logic signed [W2-1:0] LO_W  = {{(W2-DATA_W){LOWER[DATA_W-1]}}, LOWER};
    localparam logic [W2-1:0]        RND_W = {{(W2-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ZERO} clr_state_t;

    clr_state_t      state, state_nxt;
    logic [1:0]      drain_cnt, drain_cnt_nxt;
    logic [CH_W-1:0] zero_ch, zero_ch_nxt;
    logic            busy, zero_en;

    logic [DATA_W-1:0] x_prev [N_CH];
    logic [DATA_W-1:0] y_prev [N_CH];

    logic              s1_v, s1_frz;
    logic [CH_W-1:0]   s1_ch;
    logic [DATA_W-1:0] s1_x, s1_xp, s1_yp;

    logic              s2_v, s2_frz;
    logic [CH_W-1:0]   s2_ch;
    logic [DATA_W-1:0] s2_x, s2_yp;
    logic [PW-1:0]     s2_p1, s2_p2;
    logic [W2-1:0]     s2_sum;

    logic                 s3_v, s3_frz;
    logic [CH_W-1:0]      s3_ch;
    logic [DATA_W-1:0]    s3_x, s3_yp;
    logic signed [W2-1:0] s3_r;

    logic [DATA_W-1:0] y_new;
    logic              sat_new;
    logic              ch_ok, hazard, accept;

    // Issue control: block same-channel samples while any stage holds that channel.
    always_comb begin
        ch_ok  = int'(bus.in_ch) < N_CH;
        hazard = (s1_v && (s1_ch == bus.in_ch)) ||
                 (s2_v && (s2_ch == bus.in_ch)) ||
                 (s3_v && (s3_ch == bus.in_ch));
        bus.in_ready = !rst && !busy && !hazard;
        accept = bus.in_valid && bus.in_ready;
        bus.busy = busy;
    end

    // Clear sequencer next-state: drain down-counter, then walk the channels.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        zero_ch_nxt   = zero_ch;
        busy          = 1'b1;
        zero_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.clr) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = 2'd2;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'd0) begin
                    state_nxt   = ST_ZERO;
                    zero_ch_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt - 2'd1;
                end
            end
            ST_ZERO: begin
                zero_en = 1'b1;
                if (int'(zero_ch) == N_CH - 1) begin
                    state_nxt = ST_IDLE;
                end else begin
                    zero_ch_nxt = zero_ch + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Clear sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            zero_ch   <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            zero_ch   <= zero_ch_nxt;
        end
    end

    assign s2_sum = ({{(W2-DATA_W){s2_yp[DATA_W-1]}}, s2_yp} << FRAC_W)
                  + {{2{s2_p1[PW-1]}}, s2_p1}
                  + {{2{s2_p2[PW-1]}}, s2_p2}
                  + RND_W;

    // Datapath: S1 capture and state read, S2 products, S3 rounded sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0; s1_frz <= 1'b0; s1_ch <= '0;
            s1_x <= '0; s1_xp <= '0; s1_yp <= '0;
            s2_v <= 1'b0; s2_frz <= 1'b0; s2_ch <= '0;
            s2_x <= '0; s2_yp <= '0; s2_p1 <= '0; s2_p2 <= '0;
            s3_v <= 1'b0; s3_frz <= 1'b0; s3_ch <= '0;
            s3_x <= '0; s3_yp <= '0; s3_r <= '0;
        end else begin
            // out-of-range channels are accepted but never enter the pipe
            s1_v <= accept && ch_ok;
            if (accept) begin
                s1_ch  <= bus.in_ch;
                s1_x   <= bus.in_x;
                s1_frz <= bus.in_freeze;
                s1_xp  <= ch_ok ? x_prev[bus.in_ch] : '0;
                s1_yp  <= ch_ok ? y_prev[bus.in_ch] : '0;
            end

            s2_v   <= s1_v;
            s2_ch  <= s1_ch;
            s2_x   <= s1_x;
            s2_frz <= s1_frz;
            s2_yp  <= s1_yp;
            s2_p1  <= A_W * {{DATA_W{s1_x[DATA_W-1]}}, s1_x};
            s2_p2  <= B_W * {{DATA_W{s1_xp[DATA_W-1]}}, s1_xp};

            s3_v   <= s2_v;
            s3_ch  <= s2_ch;
            s3_x   <= s2_x;
            s3_frz <= s2_frz;
            s3_yp  <= s2_yp;
            s3_r   <= $signed(s2_sum) >>> FRAC_W;
        end
    end

    // Clamp, or pass the held integrator through when frozen.
    always_comb begin
        y_new   = s3_r[DATA_W-1:0];
        sat_new = 1'b0;
        if (s3_frz) begin
            y_new = s3_yp;
        end else if (s3_r > UP_W) begin
            y_new   = UPPER;
            sat_new = 1'b1;
        end else if (s3_r < LO_W) begin
            y_new   = LOWER;
            sat_new = 1'b1;
        end
    end

    // Result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_y     <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            bus.out_valid <= s3_v;
            if (s3_v) begin
                bus.out_ch  <= s3_ch;
                bus.out_y   <= y_new;
                bus.out_sat <= sat_new;
            end
        end
    end

    // Per-channel history: write-back of clamped result, or clear walk.
    // The drain phase guarantees write-back and zeroing never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                x_prev[i] <= '0;
                y_prev[i] <= '0;
            end
        end else begin
            if (s3_v) begin
                x_prev[s3_ch] <= s3_x;
                y_prev[s3_ch] <= y_new;
            end
            if (zero_en) begin
                x_prev[zero_ch] <= '0;
                y_prev[zero_ch] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pi_integrator_mc.sv
// Directed bench for pi_integrator_mc with default parameters
// (A = 1.5, B = -0.5, clamps +/-2.0, Q16.16).
module tb_pi_integrator_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pi_integrator_mc_if #(.DATA_W(32), .CH_W(3)) bus ();

    pi_integrator_mc dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] x;
        bit          frz;
        logic [31:0] y;
        bit          sat;
    } vec_t;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] y;
        bit          sat;
    } res_t;

    int     n_vec = 0;
    int     n_bad = 0;
    res_t   obs_q [$];
    res_t   exp_q [$];
    longint mdl_x [8];
    longint mdl_y [8];
    vec_t   vt [12];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Capture every result strobe.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1)
            obs_q.push_back('{bus.out_ch, bus.out_y, bus.out_sat});
    end

    task automatic mdl_zero();
        for (int i = 0; i < 8; i++) begin
            mdl_x[i] = 0;
            mdl_y[i] = 0;
        end
    endtask

    // Reference integrator in plain 64-bit arithmetic.
    task automatic mdl_step(input int ch, input logic [31:0] x, input bit frz,
                            output logic [31:0] y, output bit sat);
        longint xs, r;
        xs  = longint'($signed(x));
        sat = 1'b0;
        if (frz) begin
            y = 32'(mdl_y[ch]);
        end else begin
            r = mdl_y[ch] * 65536 + 98304 * xs - 32768 * mdl_x[ch] + 32768;
            r = r >>> 16;
            if (r > 131072) begin
                y = 32'h0002_0000; sat = 1'b1;
            end else if (r < -131072) begin
                y = 32'hFFFE_0000; sat = 1'b1;
            end else begin
                y = 32'(r);
            end
        end
        mdl_x[ch] = xs;
        mdl_y[ch] = longint'($signed(y));
    endtask

    task automatic mdl_push(input int ch, input logic [31:0] x, input bit frz);
        logic [31:0] y;
        bit s;
        mdl_step(ch, x, frz, y, s);
        exp_q.push_back('{3'(ch), y, s});
    endtask

    task automatic drive_accept(input logic [2:0] ch, input logic [31:0] x, input bit frz,
                                output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = ch; bus.in_x = x; bus.in_freeze = frz;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.in_freeze = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        bit ok;
        int lat;
        logic [31:0] my;
        bit ms;
        drive_accept(v.ch, v.x, v.frz, ok);
        chk({nm, "_accept"}, 32'(ok), 32'd1);
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            if (bus.out_valid) begin
                lat = c - 1;
                break;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        chk({nm, "_ch"},  32'(bus.out_ch), 32'(v.ch));
        chk({nm, "_y"},   bus.out_y, v.y);
        chk({nm, "_sat"}, 32'(bus.out_sat), 32'(v.sat));
        @(negedge clk); #1;
        chk({nm, "_pulse"}, 32'(bus.out_valid), 32'd0);
        mdl_step(v.ch, v.x, v.frz, my, ms);
        obs_q.delete();
    endtask

    task automatic collect(input int n, input string nm);
        res_t o, e;
        int waited;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (obs_q.size() == 0 && waited < 20) begin
                @(negedge clk); #1;
                waited++;
            end
            if (obs_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL %s_timeout: got no result, expected %0d more", nm, n - k);
                exp_q.delete();
                break;
            end
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({nm, "_ch"},  32'(o.ch), 32'(e.ch));
            chk({nm, "_y"},   o.y, e.y);
            chk({nm, "_sat"}, 32'(o.sat), 32'(e.sat));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, busy_cyc, rdy_bad;
        bit ok;

        vt[0]  = '{3'd0, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0};
        vt[1]  = '{3'd0, 32'h0001_0000, 1'b0, 32'h0002_0000, 1'b1};
        vt[2]  = '{3'd0, 32'h0001_0000, 1'b0, 32'h0002_0000, 1'b1};
        vt[3]  = '{3'd1, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0};
        vt[4]  = '{3'd2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[5]  = '{3'd4, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0};
        vt[6]  = '{3'd4, 32'h0002_0000, 1'b1, 32'h0001_8000, 1'b0};
        vt[7]  = '{3'd4, 32'h0000_0000, 1'b0, 32'h0000_8000, 1'b0};
        vt[8]  = '{3'd5, 32'hFFFE_0000, 1'b0, 32'hFFFE_0000, 1'b1};
        vt[9]  = '{3'd6, 32'h0000_8000, 1'b0, 32'h0000_C000, 1'b0};
        vt[10] = '{3'd5, 32'h0001_0000, 1'b0, 32'h0000_8000, 1'b0};
        vt[11] = '{3'd1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0};

        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_ch = '0;
        bus.in_x = '0; bus.in_freeze = 1'b0;
        mdl_zero();

        // reset state
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_out_y", bus.out_y, 32'd0);

        for (int i = 0; i < 12; i++)
            run_vec(vt[i], $sformatf("vec%0d", i));

        // interlock: same channel held, second accept 4 edges after the first
        obs_q.delete();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 3'd3; bus.in_x = 32'h0000_4000; #1;
        first = -1; second = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    break;
                end
            end
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("interlock_spacing", 32'(second - first), 32'd4);
        mdl_push(3, 32'h0000_4000, 1'b0);
        mdl_push(3, 32'h0000_4000, 1'b0);
        collect(2, "interlock");

        // round robin over all channels at full rate
        obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_ch = 3'(i);
            bus.in_x = 32'(i * 24576 - 81920); #1;
            chk($sformatf("rr_ready%0d", i), 32'(bus.in_ready), 32'd1);
            mdl_push(i, 32'(i * 24576 - 81920), 1'b0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        collect(8, "rr");

        // clear with a sample accepted on the same edge; re-pulse while busy
        obs_q.delete();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 3'd5; bus.in_x = 32'h0001_0000; bus.clr = 1'b1; #1;
        chk("clr_same_cycle_ready", 32'(bus.in_ready), 32'd1);
        mdl_push(5, 32'h0001_0000, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.clr = 1'b0; bus.in_ch = 3'd2;
        busy_cyc = 0; rdy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.clr = 1'b0;
            #1;
            if (bus.busy) begin
                busy_cyc++;
                if (bus.in_ready) rdy_bad++;
                if (busy_cyc == 5) bus.clr = 1'b1;
            end else if (busy_cyc > 0) begin
                break;
            end
        end
        bus.clr = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cyc), 32'd11);
        chk("clr_ready_while_busy", 32'(rdy_bad), 32'd0);
        collect(1, "clr_drain");
        mdl_zero();
        run_vec('{3'd0, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0}, "clr_ch0");
        run_vec('{3'd5, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0}, "clr_ch5");
        run_vec('{3'd7, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0}, "clr_ch7_xprev");

        // async reset with three samples in flight
        obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_ch = 3'(i); bus.in_x = 32'h0001_0000;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_y", bus.out_y, 32'd0);
        chk("arst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("arst_out_sat", 32'(bus.out_sat), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("arst_no_output", 32'(obs_q.size()), 32'd0);
        mdl_zero();
        run_vec('{3'd0, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0}, "arst_ch0");
        run_vec('{3'd1, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0}, "arst_ch1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
